// File: rtl/regfile_scoreboard.sv
// Hazard scoreboard and write-port arbiter for the 8x16 register file.
// It counts in-flight writes per register and stalls decode on RAW or counter-full hazards.
// It also shares the single write port between writeback and a debug loader.
module regfile_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issueValid,
  input  logic [2:0]  issueSr1,
  input  logic        issueUseSr1,
  input  logic [2:0]  issueSr2,
  input  logic        issueUseSr2,
  input  logic [2:0]  issueDr,
  input  logic        issueWritesDr,
  output logic        issueStall,
  input  logic        wbValid,
  input  logic [2:0]  wbDr,
  input  logic [15:0] wbData,
  input  logic        dbgValid,
  input  logic [2:0]  dbgDr,
  input  logic [15:0] dbgData,
  output logic        dbgReady,
  input  logic        flush,
  output logic        rfWe,
  output logic [2:0]  rfDr,
  output logic [15:0] rfDataIn,
  output logic [7:0]  busyVec,
  output logic        sbErr
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_pend [NUM_REGS];
  logic [NUM_REGS-1:0]     r_busy;
  logic                    r_err;

  logic [CNT_W-1:0]        w_pend_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]     w_busy;
  logic [NUM_REGS-1:0]     w_busy_nxt;
  logic [NUM_REGS-1:0]     w_inc;
  logic [NUM_REGS-1:0]     w_dec;
  logic                    w_hazard;
  logic                    w_stall;
  logic                    w_accept;
  logic                    w_err_set;

  // Busy flags derived from the current (registered) counters.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_busy[r] = (r_pend[r] != CNT_ZERO);
    end
  end

  // Issue hazard check; no bypass from a same-cycle writeback.
  always_comb begin
    w_hazard = issueValid &
               ((issueUseSr1 & w_busy[issueSr1]) |
                (issueUseSr2 & w_busy[issueSr2]) |
                (issueWritesDr & (r_pend[issueDr] == CNT_MAX)));
    w_stall  = w_hazard | (r_state != ST_IDLE) | ((r_state == ST_IDLE) & dbgValid);
    w_accept = issueValid & ~w_stall;
  end

  // Next counter values: increment on accepted writer, decrement on retire, clear on flush.
  always_comb begin
    w_err_set = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc[r]      = w_accept & issueWritesDr & (issueDr == 3'(r));
      w_dec[r]      = wbValid & (wbDr == 3'(r)) & w_busy[r];
      w_pend_nxt[r] = r_pend[r];
    end
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        w_pend_nxt[r] = CNT_ZERO;
      end
    end else begin
      w_err_set = wbValid & ~w_busy[wbDr];
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_inc[r] & ~w_dec[r]) begin
          w_pend_nxt[r] = r_pend[r] + CNT_ONE;
        end else if (~w_inc[r] & w_dec[r]) begin
          w_pend_nxt[r] = r_pend[r] - CNT_ONE;
        end else begin
          w_pend_nxt[r] = r_pend[r];
        end
      end
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      w_busy_nxt[r] = (w_pend_nxt[r] != CNT_ZERO);
    end
  end

  // Counter, busy-view and sticky error state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_pend[r] <= CNT_ZERO;
      end
      r_busy <= {NUM_REGS{1'b0}};
      r_err  <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_pend[r] <= w_pend_nxt[r];
      end
      r_busy <= w_busy_nxt;
      r_err  <= r_err | w_err_set;
    end
  end

  // Debug loader FSM; a flush counts as drained so WRITE follows on the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dbgValid) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if ((~|w_busy | flush) & ~wbValid) begin
            r_state <= ST_WRITE;
          end else begin
            r_state <= ST_DRAIN;
          end
        end
        ST_WRITE: begin
          if (wbValid) begin
            r_state <= ST_WRITE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write-port mux; writeback always wins, and all strobes are held low in reset.
  always_comb begin
    rfWe     = 1'b0;
    rfDr     = 3'd0;
    rfDataIn = 16'd0;
    dbgReady = 1'b0;
    if (!rst_n) begin
      rfWe = 1'b0;
    end else if (wbValid) begin
      rfWe     = 1'b1;
      rfDr     = wbDr;
      rfDataIn = wbData;
    end else if (r_state == ST_WRITE) begin
      rfWe     = 1'b1;
      rfDr     = dbgDr;
      rfDataIn = dbgData;
      dbgReady = 1'b1;
    end else begin
      rfWe = 1'b0;
    end
  end

  assign issueStall = rst_n & w_stall;
  assign busyVec    = r_busy;
  assign sbErr      = r_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; the expected values are worked out by hand.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issueValid, issueUseSr1, issueUseSr2, issueWritesDr;
  logic [2:0]  issueSr1, issueSr2, issueDr;
  logic        issueStall;
  logic        wbValid;
  logic [2:0]  wbDr;
  logic [15:0] wbData;
  logic        dbgValid;
  logic [2:0]  dbgDr;
  logic [15:0] dbgData;
  logic        dbgReady;
  logic        flush;
  logic        rfWe;
  logic [2:0]  rfDr;
  logic [15:0] rfDataIn;
  logic [7:0]  busyVec;
  logic        sbErr;

  int n_checks = 0;
  int n_errs   = 0;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issueValid(issueValid), .issueSr1(issueSr1), .issueUseSr1(issueUseSr1),
    .issueSr2(issueSr2), .issueUseSr2(issueUseSr2), .issueDr(issueDr),
    .issueWritesDr(issueWritesDr), .issueStall(issueStall),
    .wbValid(wbValid), .wbDr(wbDr), .wbData(wbData),
    .dbgValid(dbgValid), .dbgDr(dbgDr), .dbgData(dbgData), .dbgReady(dbgReady),
    .flush(flush), .rfWe(rfWe), .rfDr(rfDr), .rfDataIn(rfDataIn),
    .busyVec(busyVec), .sbErr(sbErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    issueValid = 1'b0; issueUseSr1 = 1'b0; issueUseSr2 = 1'b0; issueWritesDr = 1'b0;
    issueSr1 = 3'd0; issueSr2 = 3'd0; issueDr = 3'd0;
    wbValid = 1'b0; wbDr = 3'd0; wbData = 16'h0000;
    flush = 1'b0;
  endtask

  task automatic wr(input logic [2:0] dr);
    issueValid = 1'b1; issueWritesDr = 1'b1; issueDr = dr;
    issueUseSr1 = 1'b0; issueUseSr2 = 1'b0;
  endtask

  task automatic wb(input logic [2:0] dr, input logic [15:0] d);
    wbValid = 1'b1; wbDr = dr; wbData = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    dbgValid = 1'b0; dbgDr = 3'd0; dbgData = 16'h0000;
    rst_n = 1'b0;
    // Outputs must stay quiet while reset is held, even with requests present.
    wr(3'd1); wb(3'd2, 16'hFFFF); #1;
    check("rst_stall", issueStall, 0);
    check("rst_rfwe", rfWe, 0);
    tick(); tick();
    check("rst_busy", busyVec, 8'h00);
    check("rst_err", sbErr, 0);
    clr(); rst_n = 1'b1; #1;

    // 1: RAW on R3
    wr(3'd3); #1;
    check("t1_acc", issueStall, 0);
    tick(); clr();
    check("t1_busy", busyVec, 8'h08);
    issueValid = 1'b1; issueUseSr1 = 1'b1; issueSr1 = 3'd3; #1;
    check("t1_raw", issueStall, 1);
    tick();
    wb(3'd3, 16'h00AB); #1;
    check("t1_we", rfWe, 1);
    check("t1_dr", rfDr, 3);
    check("t1_data", rfDataIn, 16'h00AB);
    check("t1_nobypass", issueStall, 1);
    tick();
    wbValid = 1'b0; #1;
    check("t1_clear", issueStall, 0);
    check("t1_busy0", busyVec, 8'h00);
    tick(); clr(); #1;

    // 2: counter saturation on R5
    wr(3'd5);
    for (int i = 0; i < 3; i++) begin
      #1; check("t2_acc", issueStall, 0);
      tick();
    end
    check("t2_busy", busyVec, 8'h20);
    check("t2_full", issueStall, 1);
    tick();
    wb(3'd5, 16'h0005); #1;
    check("t2_full_wb", issueStall, 1);
    tick();
    wbValid = 1'b0; #1;
    check("t2_acc4", issueStall, 0);
    tick();
    check("t2_full_again", issueStall, 1);
    clr();
    wb(3'd5, 16'h0001); tick(); tick(); tick();
    clr(); #1;
    check("t2_drained", busyVec, 8'h00);
    check("t2_noerr", sbErr, 0);

    // 3: simultaneous inc and dec on R2
    wr(3'd2); tick(); clr();
    wr(3'd2); wb(3'd2, 16'h0022); #1;
    check("t3_acc", issueStall, 0);
    tick(); clr();
    check("t3_busy", busyVec, 8'h04);
    wb(3'd2, 16'h0022); tick(); clr(); #1;
    check("t3_busy0", busyVec, 8'h00);

    // 4: debug write waits for drain
    wr(3'd1); tick(); clr();
    dbgValid = 1'b1; dbgDr = 3'd7; dbgData = 16'h1234; #1;
    check("t4_req_stall", issueStall, 1);
    check("t4_req_we", rfWe, 0);
    tick();
    issueValid = 1'b1; #1;
    check("t4_drain_stall", issueStall, 1);
    check("t4_drain_rdy", dbgReady, 0);
    tick();
    check("t4_drain_we", rfWe, 0);
    wb(3'd1, 16'h5555); #1;
    check("t4_wb_dr", rfDr, 1);
    check("t4_wb_rdy", dbgReady, 0);
    tick();
    wbValid = 1'b0; #1;
    check("t4_wait_rdy", dbgReady, 0);
    tick();
    check("t4_w_we", rfWe, 1);
    check("t4_w_dr", rfDr, 7);
    check("t4_w_data", rfDataIn, 16'h1234);
    check("t4_w_rdy", dbgReady, 1);
    tick();
    dbgValid = 1'b0; #1;
    check("t4_idle_rdy", dbgReady, 0);
    check("t4_idle_we", rfWe, 0);
    check("t4_idle_stall", issueStall, 0);
    clr(); tick();

    // 5: sticky error, flush, reset mid-drain
    wb(3'd4, 16'h0044); tick(); clr();
    check("t5_err", sbErr, 1);
    check("t5_busy", busyVec, 8'h00);
    tick(); tick();
    check("t5_err_sticky", sbErr, 1);
    wr(3'd0); tick(); wr(3'd1); tick(); tick(); clr();
    check("t5_busy_pre", busyVec, 8'h03);
    flush = 1'b1; wr(3'd6); wb(3'd0, 16'h0F0F); #1;
    check("t5_flush_we", rfWe, 1);
    tick(); clr();
    check("t5_flush_busy", busyVec, 8'h00);
    check("t5_flush_err", sbErr, 1);
    wr(3'd2); tick(); clr();
    dbgValid = 1'b1; dbgDr = 3'd3; dbgData = 16'hBEEF;
    tick(); tick();
    check("t5_drain_rdy", dbgReady, 0);
    rst_n = 1'b0; #1;
    check("t5_rst_rdy", dbgReady, 0);
    check("t5_rst_stall", issueStall, 0);
    tick();
    rst_n = 1'b1; dbgValid = 1'b0; #1;
    check("t5_post_busy", busyVec, 8'h00);
    check("t5_post_err", sbErr, 0);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_rdy", dbgReady, 0);
      check("t5_no_we", rfWe, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
